p_id_ex_pipe_ctrl: RTL and testbench
====================================

Name: p_id_ex_pipe_ctrl

Overview:
- Parametrised ID/EX pipeline boundary register with a valid bit, flush, load-use bubble insertion and a multi-cycle hold FSM for long RV32M ops (div/rem).
- Sits between the decode/register-read logic and the EX stage.
- Captures decoded operands and a packed control bundle.
- Tells IF/ID when to freeze.

Parameters:
- XLEN, 32, datapath width of pc, operand and immediate fields.
- CTRL_W, 16, width of the packed control bundle (alu_op, branch_op, wb_sel, alu_src, mem enables, funct3).
- LONG_LAT, 34, total EX occupancy in cycles of a long op; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  ID holds a real instruction
- i_pc  in  XLEN  pc of ID instruction
- i_pc_plus_4  in  XLEN  pc+4 of ID instruction
- i_rs1_data  in  XLEN  register-file read data, port 1
- i_rs2_data  in  XLEN  register-file read data, port 2
- i_imm  in  XLEN  decoded immediate
- i_rs1_addr  in  5  source address 1
- i_rs2_addr  in  5  source address 2
- i_rd_addr  in  5  destination address
- i_uses_rs1  in  1  instruction reads rs1
- i_uses_rs2  in  1  instruction reads rs2
- i_reg_write_en  in  1  instruction writes rd
- i_is_load  in  1  instruction is a load
- i_is_long  in  1  instruction is div/divu/rem/remu
- i_ctrl  in  CTRL_W  packed control bundle
- i_flush  in  1  kill the ID and EX contents (branch/jump redirect)
- o_valid  out  1  EX slot holds a real instruction
- o_pc  out  XLEN  registered i_pc
- o_pc_plus_4  out  XLEN  registered i_pc_plus_4
- o_rs1_data  out  XLEN  registered i_rs1_data
- o_rs2_data  out  XLEN  registered i_rs2_data
- o_imm  out  XLEN  registered i_imm
- o_rd_addr  out  5  registered i_rd_addr
- o_reg_write_en  out  1  registered write enable, qualified by valid
- o_is_load  out  1  registered load flag, qualified by valid
- o_ctrl  out  CTRL_W  registered control bundle; zero when not valid
- o_stall_id  out  1  freeze PC and IF/ID this cycle (combinational)
- o_ex_busy  out  1  long op occupying EX
- o_long_done  out  1  one-cycle pulse in the final cycle of a long op

Behaviour:
- Reset, sync, active-high: all outputs 0; FSM IDLE; counter 0. Reset mid long-op aborts it, with no o_long_done pulse.
- Latency: one cycle, ID to EX.
- Priority each edge: rst > i_flush > BUSY hold > load-use bubble > normal capture.
- Load-use hazard (comb), asserted when all of the following hold:
  - o_valid, o_is_load, o_reg_write_en, o_rd_addr != 0 and i_valid;
  - and either (i_uses_rs1 and i_rs1_addr == o_rd_addr) or (i_uses_rs2 and i_rs2_addr == o_rd_addr).
- On load-use hazard: o_stall_id = 1 and the next edge loads a bubble (o_valid = 0, o_ctrl = 0, o_reg_write_en = 0, o_is_load = 0). Exactly one bubble cycle per hazard.
- Normal capture: all fields load from inputs. o_valid <= i_valid. Control outputs are forced to 0 when i_valid = 0. Data fields load regardless (don't-care).
- Flush: next o_valid = 0 and control outputs = 0; FSM -> IDLE; counter cleared. No o_long_done pulse. o_stall_id = 0 in a flush cycle.
- FSM states IDLE and BUSY; counter is $clog2(LONG_LAT) bits.
  - IDLE -> BUSY: on the edge after a captured valid instruction with i_is_long, counter <= LONG_LAT-2. That instruction was already in EX for 1 cycle.
  - BUSY: EX registers hold; o_ex_busy = 1; o_stall_id = 1; counter decrements each cycle.
  - BUSY, counter == 0: o_long_done = 1 and o_stall_id = 0. The next edge captures the next ID instruction normally and the FSM returns to IDLE. If that instruction is also long, the FSM re-enters BUSY via the IDLE rule.
  - Net result: a long op occupies EX for exactly LONG_LAT cycles.
- Long-op tracking uses a registered long flag; it is not exposed as a port.
- The load-use check is evaluated in BUSY but is masked by the BUSY hold, which freezes ID anyway.
- i_flush while BUSY: abort and bubble as above.

Optional Feature:
- Macro P_ID_EX_LONG_OP_EN.
- Defined: the FSM, counter, o_ex_busy and o_long_done are present as described.
- Undefined: i_is_long is ignored; o_ex_busy and o_long_done are tied to 0; the FSM and counter are not synthesised; every instruction occupies EX for 1 cycle. Use this for an RV32I-only build.

Decomposition:
- Shared package p_pipe_pkg holds:
  - ex_state_t enum {EX_IDLE, EX_BUSY};
  - ctrl_bundle_t packed struct whose $bits defines the CTRL_W default;
  - constant DEFAULT_LONG_LAT = 34.
- Sub-module p_load_use_detect: purely combinational hazard compare, reusable by a future forwarding unit.
- Field registers reuse the existing p_reg.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, o_stall_id=0; first valid addi after rst falls appears at o_valid=1 one cycle later.
- Load-use: lw x5 in EX, then add x6,x5,x1 in ID -> o_stall_id=1 for 1 cycle, then o_valid=0 bubble, then add captured with o_rd_addr=6. Same case with rd=x0 -> no stall.
- Flush: valid add in ID with i_flush=1 -> next cycle o_valid=0, o_ctrl=0, o_reg_write_en=0.
- Long op, LONG_LAT=34: div captured -> o_ex_busy high 33 cycles, o_long_done single pulse in cycle 34, o_rs1_data stable throughout, next instruction captured the following edge.
- Flush at cycle 10 of a div -> o_ex_busy drops next cycle, no o_long_done, o_valid=0.
- Back-to-back div, div -> each occupies 34 cycles, two o_long_done pulses 34 cycles apart. With P_ID_EX_LONG_OP_EN undefined the same stimulus shows o_ex_busy=0 and 1-cycle occupancy each.

Source files
------------

// File: rtl/p_pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline boundary and its helpers.
package p_pipe_pkg;

  typedef enum logic [0:0] {
    EX_IDLE = 1'b0,
    EX_BUSY = 1'b1
  } ex_state_t;

  // Packed control bundle carried from decode into EX.
  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] branch_op;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic       mem_re;
    logic       mem_we;
    logic [2:0] funct3;
    logic       rsvd;
  } ctrl_bundle_t;

  localparam int DEFAULT_CTRL_W   = $bits(ctrl_bundle_t);
  localparam int DEFAULT_LONG_LAT = 34;

  // True when a source port is actually read and names the given register.
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/p_load_use_detect.sv
// Combinational load-use hazard compare between the EX slot and the ID instruction.
module p_load_use_detect
  import p_pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic       ex_reg_write_en,
  input  logic [4:0] ex_rd_addr,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  output logic       hazard
);

  logic ex_load_pending;
  logic src_hit;

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign ex_load_pending = ex_valid && ex_is_load && ex_reg_write_en && (ex_rd_addr != 5'd0);
  assign src_hit = src_match(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                   src_match(id_uses_rs2, id_rs2_addr, ex_rd_addr);
  assign hazard = ex_load_pending && id_valid && src_hit;

endmodule

// File: rtl/p_reg.sv
// Generic enabled register with synchronous active-high clear.
module p_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/p_id_ex_pipe_ctrl.sv
// ID/EX boundary register with flush, load-use bubble and long-op hold.
// Define P_ID_EX_LONG_OP_EN to build the multi-cycle hold FSM for div/rem.
module p_id_ex_pipe_ctrl
  import p_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CTRL_W   = DEFAULT_CTRL_W,
  parameter int LONG_LAT = DEFAULT_LONG_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_pc_plus_4,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [4:0]        i_rs1_addr,
  input  logic [4:0]        i_rs2_addr,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_uses_rs1,
  input  logic              i_uses_rs2,
  input  logic              i_reg_write_en,
  input  logic              i_is_load,
  input  logic              i_is_long,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_pc_plus_4,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [XLEN-1:0]   o_imm,
  output logic [4:0]        o_rd_addr,
  output logic              o_reg_write_en,
  output logic              o_is_load,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_stall_id,
  output logic              o_ex_busy,
  output logic              o_long_done
);

  localparam int DATA_W = 5 * XLEN + 5;
  localparam int CTL_W  = CTRL_W + 3;

  logic              load_use;
  logic              ex_hold;
  logic              cap_en;
  logic              capture_ok;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic [CTL_W-1:0]  ctl_d;
  logic [CTL_W-1:0]  ctl_q;

  p_load_use_detect u_load_use (
    .ex_valid        (o_valid),
    .ex_is_load      (o_is_load),
    .ex_reg_write_en (o_reg_write_en),
    .ex_rd_addr      (o_rd_addr),
    .id_valid        (i_valid),
    .id_uses_rs1     (i_uses_rs1),
    .id_uses_rs2     (i_uses_rs2),
    .id_rs1_addr     (i_rs1_addr),
    .id_rs2_addr     (i_rs2_addr),
    .hazard          (load_use)
  );

  // Flush always loads (as a bubble); otherwise a long-op hold freezes EX.
  assign cap_en     = i_flush || !ex_hold;
  assign capture_ok = i_valid && !load_use && !i_flush;

  assign data_d = {i_pc, i_pc_plus_4, i_rs1_data, i_rs2_data, i_imm, i_rd_addr};
  assign ctl_d  = capture_ok ? {1'b1, i_reg_write_en, i_is_load, i_ctrl} : '0;

  p_reg #(.W(DATA_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (cap_en),
    .d   (data_d),
    .q   (data_q)
  );

  p_reg #(.W(CTL_W)) u_ctl_reg (
    .clk (clk),
    .rst (rst),
    .en  (cap_en),
    .d   (ctl_d),
    .q   (ctl_q)
  );

  assign {o_pc, o_pc_plus_4, o_rs1_data, o_rs2_data, o_imm, o_rd_addr} = data_q;
  assign {o_valid, o_reg_write_en, o_is_load, o_ctrl} = ctl_q;

  assign o_stall_id = !i_flush && (ex_hold || load_use);

`ifdef P_ID_EX_LONG_OP_EN
  localparam int         CNT_W   = $clog2(LONG_LAT);
  localparam logic [0:0] ST_IDLE = EX_IDLE;
  localparam logic [0:0] ST_BUSY = EX_BUSY;

  logic [0:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ex_long_q;
  logic             at_last;

  assign at_last = (state_q == ST_BUSY) && (cnt_q == '0);

  // The first EX cycle of a long op is spent in IDLE, so it must hold too.
  assign ex_hold = ((state_q == ST_IDLE) && o_valid && ex_long_q) ||
                   ((state_q == ST_BUSY) && !at_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ex_long_q <= 1'b0;
    end else if (i_flush) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ex_long_q <= 1'b0;
    end else begin
      if (cap_en) begin
        ex_long_q <= capture_ok && i_is_long;
      end
      case (state_q)
        ST_IDLE: begin
          if (o_valid && ex_long_q) begin
            state_q <= ST_BUSY;
            cnt_q   <= CNT_W'(LONG_LAT - 2);
          end
        end
        default: begin
          if (at_last) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign o_ex_busy   = (state_q == ST_BUSY);
  assign o_long_done = at_last && !i_flush && !rst;
`else
  logic [32:0] unused_long_cfg;

  assign unused_long_cfg = {i_is_long, 32'(LONG_LAT)};
  assign ex_hold         = 1'b0;
  assign o_ex_busy       = 1'b0;
  assign o_long_done     = 1'b0;
`endif

endmodule

// File: tb/tb_p_id_ex_pipe_ctrl.sv
// Self-checking bench for p_id_ex_pipe_ctrl: occupancy-based reference model plus directed cases.
module tb_p_id_ex_pipe_ctrl;

  localparam int XLEN = 32;
  localparam int CW   = 16;
  localparam int LL   = 34;
`ifdef P_ID_EX_LONG_OP_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic [XLEN-1:0] i_pc, i_pc_plus_4, i_rs1_data, i_rs2_data, i_imm;
  logic [4:0]      i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic            i_uses_rs1, i_uses_rs2, i_reg_write_en, i_is_load, i_is_long;
  logic [CW-1:0]   i_ctrl;
  logic            i_flush;
  logic            o_valid;
  logic [XLEN-1:0] o_pc, o_pc_plus_4, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]      o_rd_addr;
  logic            o_reg_write_en, o_is_load;
  logic [CW-1:0]   o_ctrl;
  logic            o_stall_id, o_ex_busy, o_long_done;

  int n_cmp = 0;
  int n_err = 0;

  p_id_ex_pipe_ctrl #(.XLEN(XLEN), .CTRL_W(CW), .LONG_LAT(LL)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_pc(i_pc), .i_pc_plus_4(i_pc_plus_4),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
    .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2), .i_reg_write_en(i_reg_write_en),
    .i_is_load(i_is_load), .i_is_long(i_is_long), .i_ctrl(i_ctrl), .i_flush(i_flush),
    .o_valid(o_valid), .o_pc(o_pc), .o_pc_plus_4(o_pc_plus_4), .o_rs1_data(o_rs1_data),
    .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_rd_addr(o_rd_addr),
    .o_reg_write_en(o_reg_write_en), .o_is_load(o_is_load), .o_ctrl(o_ctrl),
    .o_stall_id(o_stall_id), .o_ex_busy(o_ex_busy), .o_long_done(o_long_done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // EX contents plus how many cycles the current instruction has sat in EX.
  bit            started = 1'b0;
  bit            m_valid, m_we, m_ld, m_long;
  logic [CW-1:0] m_ctrl;
  logic [XLEN-1:0] m_pc, m_pc4, m_rs1, m_rs2, m_imm;
  logic [4:0]    m_rd;
  int            m_age;

  function automatic bit mdl_hazard();
    return m_valid && m_ld && m_we && (m_rd != 5'd0) && i_valid &&
           ((i_uses_rs1 && i_rs1_addr == m_rd) || (i_uses_rs2 && i_rs2_addr == m_rd));
  endfunction

  function automatic bit mdl_hold();
    return LONG_EN && m_valid && m_long && (m_age < LL);
  endfunction

  always @(posedge clk) begin : mdl
    bit hz, hd, keep;
    hz = mdl_hazard();
    hd = mdl_hold();
    if (rst) begin
      started = 1'b1;
      m_valid = 0; m_we = 0; m_ld = 0; m_long = 0; m_ctrl = '0; m_age = 0;
      m_pc = '0; m_pc4 = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_rd = '0;
    end else if (i_flush) begin
      m_valid = 0; m_we = 0; m_ld = 0; m_long = 0; m_ctrl = '0; m_age = 0;
    end else if (hd) begin
      m_age++;
    end else begin
      keep    = i_valid && !hz;
      m_valid = keep;
      m_we    = keep && i_reg_write_en;
      m_ld    = keep && i_is_load;
      m_long  = keep && i_is_long;
      m_ctrl  = keep ? i_ctrl : '0;
      m_pc = i_pc; m_pc4 = i_pc_plus_4; m_rs1 = i_rs1_data; m_rs2 = i_rs2_data;
      m_imm = i_imm; m_rd = i_rd_addr;
      m_age   = 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_q[$];

  always @(negedge clk) begin
    cyc++;
    if (o_ex_busy) busy_cnt++;
    if (o_long_done) begin
      done_cnt++;
      done_q.push_back(cyc);
    end
    if (started) begin
      chk("valid", o_valid, m_valid);
      chk("ctrl", o_ctrl, m_ctrl);
      chk("reg_we", o_reg_write_en, m_we);
      chk("is_load", o_is_load, m_ld);
      chk("stall_id", o_stall_id, !i_flush && (mdl_hazard() || mdl_hold()));
      chk("ex_busy", o_ex_busy, LONG_EN && m_valid && m_long && m_age >= 2);
      chk("long_done", o_long_done,
          LONG_EN && m_valid && m_long && m_age == LL && !i_flush && !rst);
      if (m_valid) begin
        chk("pc", o_pc, m_pc);
        chk("pc4", o_pc_plus_4, m_pc4);
        chk("rs1_data", o_rs1_data, m_rs1);
        chk("rs2_data", o_rs2_data, m_rs2);
        chk("imm", o_imm, m_imm);
        chk("rd_addr", o_rd_addr, m_rd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rd, input logic [4:0] ra,
                           input logic [4:0] rb, input logic u1, input logic u2,
                           input logic we, input logic ld, input logic lg,
                           input logic [CW-1:0] ctrl);
    i_valid = v; i_rd_addr = rd; i_rs1_addr = ra; i_rs2_addr = rb;
    i_uses_rs1 = u1; i_uses_rs2 = u2; i_reg_write_en = we; i_is_load = ld;
    i_is_long = lg; i_ctrl = ctrl;
    i_pc = $urandom; i_pc_plus_4 = i_pc + 32'd4;
    i_rs1_data = $urandom; i_rs2_data = $urandom; i_imm = $urandom;
  endtask

  task automatic set_nop();
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
    done_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int occ;
  int gap;

  initial begin
    // reset with random inputs
    rst = 1'b1;
    set_instr(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), CW'($urandom));
    i_flush = 1'($urandom);
    tick();
    tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_ctrl", o_ctrl, 0);
    chk("rst_stall", o_stall_id, 0);
    chk("rst_pc", o_pc, 0);

    // first addi x1 after reset
    rst = 1'b0;
    i_flush = 1'b0;
    set_instr(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0013);
    tick();
    chk("addi_valid", o_valid, 1);
    chk("addi_rd", o_rd_addr, 1);
    chk("addi_we", o_reg_write_en, 1);

    // lw x5 then add x6,x5,x1
    set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2203);
    tick();
    set_instr(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0033);
    #1 chk("lu_stall", o_stall_id, 1);
    tick();
    chk("lu_bubble_valid", o_valid, 0);
    chk("lu_bubble_stall", o_stall_id, 0);
    tick();
    chk("lu_add_valid", o_valid, 1);
    chk("lu_add_rd", o_rd_addr, 6);

    // load to x0 never stalls
    set_instr(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2203);
    tick();
    set_instr(1'b1, 5'd6, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0033);
    #1 chk("x0_stall", o_stall_id, 0);
    tick();
    chk("x0_add_rd", o_rd_addr, 6);

    // rs2-only dependency stalls; matching rs1 with uses_rs1=0 does not
    set_instr(1'b1, 5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2203);
    tick();
    set_instr(1'b1, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123);
    #1 chk("rs2_stall", o_stall_id, 1);
    set_instr(1'b1, 5'd9, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0037);
    #1 chk("nouse_stall", o_stall_id, 0);
    tick();

    // flush while a load-use hazard is present
    set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2203);
    tick();
    set_instr(1'b1, 5'd12, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0033);
    i_flush = 1'b1;
    #1 chk("flush_stall", o_stall_id, 0);
    tick();
    i_flush = 1'b0;
    set_nop();
    chk("flush_valid", o_valid, 0);
    chk("flush_ctrl", o_ctrl, 0);
    chk("flush_we", o_reg_write_en, 0);

    // single div followed by addi x8
    clear_counts();
    set_instr(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4033);
    tick();
    set_instr(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0013);
    occ = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_valid && o_rd_addr == 5'd8) break;
      occ++;
    end
    set_nop();
    chk("div_occupancy", occ, LONG_EN ? LL : 1);
    chk("div_busy_cycles", busy_cnt, LONG_EN ? LL - 1 : 0);
    chk("div_done_pulses", done_cnt, LONG_EN ? 1 : 0);
    tick();

    // flush in cycle 10 of a div
    clear_counts();
    set_instr(1'b1, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4033);
    tick();
    set_nop();
    repeat (9) tick();
    chk("div10_busy", o_ex_busy, LONG_EN);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("abort_busy", o_ex_busy, 0);
    chk("abort_valid", o_valid, 0);
    repeat (3) tick();
    chk("abort_no_done", done_cnt, 0);

    // back-to-back div, div
    clear_counts();
    set_instr(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4033);
    tick();
    set_instr(1'b1, 5'd10, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h6033);
    #1 chk("b2b_stall", o_stall_id, LONG_EN);
    tick();
    chk("b2b_second_ex", o_rd_addr, LONG_EN ? 9 : 10);
    for (int i = 0; i < 2 * LL + 12; i++) begin
      if (o_valid && o_rd_addr == 5'd10) set_nop();
      tick();
    end
    gap = (done_q.size() >= 2) ? done_q[1] - done_q[0] : 0;
    chk("b2b_done_pulses", done_cnt, LONG_EN ? 2 : 0);
    chk("b2b_done_gap", gap, LONG_EN ? LL : 0);
    chk("b2b_busy_cycles", busy_cnt, LONG_EN ? 2 * (LL - 1) : 0);

    // reset in the middle of a div
    clear_counts();
    set_instr(1'b1, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4033);
    tick();
    set_nop();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", o_ex_busy, 0);
    chk("midrst_valid", o_valid, 0);
    repeat (3) tick();
    chk("midrst_no_done", done_cnt, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
